// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage
//   ID/EX pipeline register with load-use hazard detection for a 5-stage
//   in-order pipeline. A load in EX whose destination is read by the
//   instruction in ID raises stall for one cycle and inserts a bubble.
//   A taken branch/jump in EX (ex_flush) kills the ID instruction, and
//   ex_flush wins over the hazard.
//
//   Optional feature: define HAZARD_STATS_EN to count load-use stall cycles
//   in stall_count (saturating). Without it stall_count is tied to zero.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   id_valid..id_imm    : decoded instruction fields from the ID stage
//   ex_flush            : kill the ID instruction (bubble into EX)
//   stall               : hold PC and IF/ID (combinational)
//   ID_EX_*             : registered EX-stage fields
//   stall_count         : load-use stall cycles since reset
module id_ex_hazard_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [1:0]      id_use,
    input  logic [2:0]      id_ctrl,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            ex_flush,
    output logic            stall,
    output logic            ID_EX_valid,
    output logic [4:0]      ID_EX_rs1,
    output logic [4:0]      ID_EX_rs2,
    output logic [4:0]      ID_EX_rd,
    output logic [2:0]      ID_EX_ctrl,
    output logic [XLEN-1:0] ID_EX_rs1_data,
    output logic [XLEN-1:0] ID_EX_rs2_data,
    output logic [XLEN-1:0] ID_EX_imm,
    output logic [31:0]     stall_count
);

    logic            id_ex_valid_q, id_ex_valid_d;
    logic [4:0]      id_ex_rs1_q, id_ex_rs1_d;
    logic [4:0]      id_ex_rs2_q, id_ex_rs2_d;
    logic [4:0]      id_ex_rd_q, id_ex_rd_d;
    logic [2:0]      id_ex_ctrl_q, id_ex_ctrl_d;
    logic [XLEN-1:0] id_ex_rs1_data_q, id_ex_rs1_data_d;
    logic [XLEN-1:0] id_ex_rs2_data_q, id_ex_rs2_data_d;
    logic [XLEN-1:0] id_ex_imm_q, id_ex_imm_d;

    logic hazard;
    logic src_match;

    // Only compare sources the ID instruction actually reads.
    always_comb begin
        src_match = (id_use[0] && (id_rs1 == id_ex_rd_q)) ||
                    (id_use[1] && (id_rs2 == id_ex_rd_q));
        hazard    = id_valid && id_ex_valid_q && id_ex_ctrl_q[1] &&
                    (id_ex_rd_q != 5'd0) && src_match;
        // Reset drops a pending stall in the same cycle.
        stall     = hazard && !ex_flush && !reset;
    end

    always_comb begin
        id_ex_valid_d    = 1'b0;
        id_ex_rs1_d      = '0;
        id_ex_rs2_d      = '0;
        id_ex_rd_d       = '0;
        id_ex_ctrl_d     = '0;
        id_ex_rs1_data_d = '0;
        id_ex_rs2_data_d = '0;
        id_ex_imm_d      = '0;
        if (!(ex_flush || hazard)) begin
            id_ex_valid_d    = id_valid;
            id_ex_rs1_d      = id_rs1;
            id_ex_rs2_d      = id_rs2;
            id_ex_rd_d       = id_rd;
            id_ex_ctrl_d     = id_valid ? id_ctrl : 3'b000;
            id_ex_rs1_data_d = id_rs1_data;
            id_ex_rs2_data_d = id_rs2_data;
            id_ex_imm_d      = id_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_valid_q    <= 1'b0;
            id_ex_rs1_q      <= '0;
            id_ex_rs2_q      <= '0;
            id_ex_rd_q       <= '0;
            id_ex_ctrl_q     <= '0;
            id_ex_rs1_data_q <= '0;
            id_ex_rs2_data_q <= '0;
            id_ex_imm_q      <= '0;
        end else begin
            id_ex_valid_q    <= id_ex_valid_d;
            id_ex_rs1_q      <= id_ex_rs1_d;
            id_ex_rs2_q      <= id_ex_rs2_d;
            id_ex_rd_q       <= id_ex_rd_d;
            id_ex_ctrl_q     <= id_ex_ctrl_d;
            id_ex_rs1_data_q <= id_ex_rs1_data_d;
            id_ex_rs2_data_q <= id_ex_rs2_data_d;
            id_ex_imm_q      <= id_ex_imm_d;
        end
    end

    assign ID_EX_valid    = id_ex_valid_q;
    assign ID_EX_rs1      = id_ex_rs1_q;
    assign ID_EX_rs2      = id_ex_rs2_q;
    assign ID_EX_rd       = id_ex_rd_q;
    assign ID_EX_ctrl     = id_ex_ctrl_q;
    assign ID_EX_rs1_data = id_ex_rs1_data_q;
    assign ID_EX_rs2_data = id_ex_rs2_data_q;
    assign ID_EX_imm      = id_ex_imm_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
module tb_id_ex_hazard_stage;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [1:0]      id_use;
    logic [2:0]      id_ctrl;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic            ex_flush;
    logic            stall;
    logic            ID_EX_valid;
    logic [4:0]      ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [2:0]      ID_EX_ctrl;
    logic [XLEN-1:0] ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
    logic [31:0]     stall_count;

    id_ex_hazard_stage #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_use         (id_use),
        .id_ctrl        (id_ctrl),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .id_imm         (id_imm),
        .ex_flush       (ex_flush),
        .stall          (stall),
        .ID_EX_valid    (ID_EX_valid),
        .ID_EX_rs1      (ID_EX_rs1),
        .ID_EX_rs2      (ID_EX_rs2),
        .ID_EX_rd       (ID_EX_rd),
        .ID_EX_ctrl     (ID_EX_ctrl),
        .ID_EX_rs1_data (ID_EX_rs1_data),
        .ID_EX_rs2_data (ID_EX_rs2_data),
        .ID_EX_imm      (ID_EX_imm),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    // Reference view of what sits in EX.
    typedef struct {
        bit          valid;
        bit [4:0]    rs1, rs2, rd;
        bit [2:0]    ctrl;
        bit [31:0]   d1, d2, imm;
    } ex_t;

    ex_t         m_ex;
    int unsigned m_cnt;
    int          checks   = 0;
    int          failures = 0;

`ifdef HAZARD_STATS_EN
    localparam bit StatsOn = 1'b1;
`else
    localparam bit StatsOn = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare against the model, then clock.
    task automatic step(input bit rst, input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit [4:0] rd, input bit [1:0] use_b, input bit [2:0] ctrl,
                        input bit flush, output bit st_seen);
        bit   reads_rd, exp_hz, exp_st;
        ex_t  nxt;
        bit [31:0] d1, d2, imm;
        d1 = $urandom; d2 = $urandom; imm = $urandom;
        @(negedge clk);
        reset = rst; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use = use_b; id_ctrl = ctrl; ex_flush = flush;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        #1;
        // A load in EX writing a real register that decode actually reads.
        reads_rd = (use_b[0] && rs1 == m_ex.rd) || (use_b[1] && rs2 == m_ex.rd);
        exp_hz   = v && m_ex.valid && m_ex.ctrl[1] && m_ex.rd != 0 && reads_rd;
        exp_st   = exp_hz && !flush && !rst;
        st_seen  = stall;
        chk("stall", {31'd0, stall}, {31'd0, exp_st});
        chk("valid", {31'd0, ID_EX_valid}, {31'd0, m_ex.valid});
        chk("rs1", {27'd0, ID_EX_rs1}, {27'd0, m_ex.rs1});
        chk("rs2", {27'd0, ID_EX_rs2}, {27'd0, m_ex.rs2});
        chk("rd", {27'd0, ID_EX_rd}, {27'd0, m_ex.rd});
        chk("ctrl", {29'd0, ID_EX_ctrl}, {29'd0, m_ex.ctrl});
        chk("rs1_data", ID_EX_rs1_data, m_ex.d1);
        chk("rs2_data", ID_EX_rs2_data, m_ex.d2);
        chk("imm", ID_EX_imm, m_ex.imm);
        chk("stall_count", stall_count, StatsOn ? m_cnt : 32'd0);
        nxt = '{default: 0};
        if (!rst && !flush && !exp_hz) begin
            nxt.valid = v; nxt.rs1 = rs1; nxt.rs2 = rs2; nxt.rd = rd;
            nxt.ctrl = v ? ctrl : 3'b000; nxt.d1 = d1; nxt.d2 = d2; nxt.imm = imm;
        end
        @(posedge clk);
        m_ex = nxt;
        if (rst) m_cnt = 0;
        else if (exp_st && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        #1;
    endtask

    bit          s;
    int unsigned cnt0;

    initial begin
        reset = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use = 0;
        id_ctrl = 0; ex_flush = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        repeat (2) @(posedge clk);
        m_ex = '{default: 0};
        m_cnt = 0;

        // Reset holds everything at zero even with a flush request.
        step(1, 1, 5, 5, 5, 2'b11, 3'b110, 1, s);
        chk("reset_valid", {31'd0, ID_EX_valid}, 32'd0);
        chk("reset_count", stall_count, 32'd0);
        // First cycle after reset: EX empty, so no stall.
        step(0, 1, 1, 2, 5, 2'b01, 3'b110, 0, s);
        chk("post_reset_stall", {31'd0, s}, 32'd0);

        // lw x5 then add x6,x5,x7: one stall, one bubble, then the add.
        step(0, 1, 1, 0, 5, 2'b01, 3'b110, 0, s);
        chk("lw_loaded_rd", {27'd0, ID_EX_rd}, 32'd5);
        step(0, 1, 5, 7, 6, 2'b11, 3'b100, 0, s);
        chk("loaduse_stall", {31'd0, s}, 32'd1);
        chk("bubble_valid", {31'd0, ID_EX_valid}, 32'd0);
        chk("bubble_ctrl", {29'd0, ID_EX_ctrl}, 32'd0);
        step(0, 1, 5, 7, 6, 2'b11, 3'b100, 0, s);
        chk("after_bubble_stall", {31'd0, s}, 32'd0);
        chk("add_rd", {27'd0, ID_EX_rd}, 32'd6);
        chk("add_ctrl", {29'd0, ID_EX_ctrl}, 32'd4);

        // lw x0 never causes a hazard.
        step(0, 1, 1, 0, 0, 2'b01, 3'b110, 0, s);
        step(0, 1, 0, 0, 9, 2'b11, 3'b100, 0, s);
        chk("x0_stall", {31'd0, s}, 32'd0);

        // Unused rs2 field matching rd is ignored.
        step(0, 1, 1, 0, 5, 2'b01, 3'b110, 0, s);
        step(0, 1, 3, 5, 9, 2'b01, 3'b100, 0, s);
        chk("unused_rs2_stall", {31'd0, s}, 32'd0);

        // Hazard plus flush: no stall, bubble, count unchanged.
        step(0, 1, 1, 0, 5, 2'b01, 3'b110, 0, s);
        cnt0 = stall_count;
        step(0, 1, 5, 5, 6, 2'b11, 3'b100, 1, s);
        chk("flush_stall", {31'd0, s}, 32'd0);
        chk("flush_valid", {31'd0, ID_EX_valid}, 32'd0);
        chk("flush_count", stall_count, cnt0);

        // Back-to-back dependent loads each stall.
        step(0, 1, 1, 0, 5, 2'b01, 3'b110, 0, s);
        step(0, 1, 5, 0, 6, 2'b01, 3'b110, 0, s);
        chk("b2b_stall1", {31'd0, s}, 32'd1);
        step(0, 1, 5, 0, 6, 2'b01, 3'b110, 0, s);
        step(0, 1, 6, 0, 7, 2'b01, 3'b100, 0, s);
        chk("b2b_stall2", {31'd0, s}, 32'd1);
        step(0, 1, 6, 0, 7, 2'b01, 3'b100, 0, s);

        // Three separated load-use pairs after a reset.
        step(1, 0, 0, 0, 0, 2'b00, 3'b000, 0, s);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 5, 2'b01, 3'b110, 0, s);
            step(0, 1, 5, 0, 6, 2'b01, 3'b100, 0, s);
            step(0, 1, 5, 0, 6, 2'b01, 3'b100, 0, s);
            step(0, 0, 0, 0, 0, 2'b00, 3'b000, 0, s);
        end
        chk("three_pairs_count", stall_count, StatsOn ? 32'd3 : 32'd0);
        step(1, 1, 1, 0, 5, 2'b01, 3'b110, 0, s);
        chk("reset_all_valid", {31'd0, ID_EX_valid}, 32'd0);
        chk("reset_all_imm", ID_EX_imm, 32'd0);
        chk("reset_all_count", stall_count, 32'd0);

        // Randomized traffic over a small register set to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0), s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_stage.md
ID_EX_HAZARD_STAGE -- requirements
Module: id_ex_hazard_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width of operand and immediate fields.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port id_valid  input  1  decode stage holds a real instruction.
REQ-005 The block SHALL have port id_rs1  input  5  decoded source register 1.
REQ-006 The block SHALL have port id_rs2  input  5  decoded source register 2.
REQ-007 The block SHALL have port id_rd  input  5  decoded destination register.
REQ-008 The block SHALL have port id_use  input  2  {uses rs2, uses rs1}.
REQ-009 The block SHALL have port id_ctrl  input  3  {reg_write, mem_read, mem_write}.
REQ-010 The block SHALL have port id_rs1_data  input  XLEN  register-file read data 1.
REQ-011 The block SHALL have port id_rs2_data  input  XLEN  register-file read data 2.
REQ-012 The block SHALL have port id_imm  input  XLEN  decoded immediate.
REQ-013 The block SHALL have port ex_flush  input  1  taken branch/jump resolved in EX; kill decode instruction.
REQ-014 The block SHALL have port stall  output  1  hold PC and IF/ID register this cycle (combinational).
REQ-015 The block SHALL have port ID_EX_valid  output  1  EX stage holds a real instruction.
REQ-016 The block SHALL have ports ID_EX_rs1, ID_EX_rs2, ID_EX_rd  output  5 each  registered register indices feeding the forwarding unit.
REQ-017 The block SHALL have port ID_EX_ctrl  output  3  registered {reg_write, mem_read, mem_write}.
REQ-018 The block SHALL have ports ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm  output  XLEN each  registered operands.
REQ-019 The block SHALL have port stall_count  output  32  load-use stall cycles since reset.

Function
REQ-020 hazard SHALL be 1 iff id_valid, ID_EX_valid, ID_EX_ctrl[1] (mem_read), ID_EX_rd != 0, and ((id_use[0] and id_rs1 == ID_EX_rd) or (id_use[1] and id_rs2 == ID_EX_rd)).
REQ-021 Source indices SHALL not be compared when the matching id_use bit is 0; rd == x0 SHALL never cause a hazard.
REQ-022 stall SHALL equal hazard and not ex_flush.
REQ-023 On each edge, if ex_flush or hazard, the register SHALL load a bubble: ID_EX_valid=0, ID_EX_ctrl=0, indices=0, data fields=0.
REQ-024 Otherwise the register SHALL load all id_* fields; ID_EX_valid=id_valid; ID_EX_ctrl=id_ctrl when id_valid, else 0.
REQ-025 Latency ID to EX SHALL be exactly one cycle; a load-use hazard SHALL insert exactly one bubble, since the bubble clears mem_read and deasserts stall on the next cycle.
REQ-026 ex_flush SHALL take priority over hazard: bubble inserted, stall=0 in the same cycle.
REQ-027 Back-to-back loads SHALL each stall independently when each second instruction depends on the first.

Reset
REQ-028 While reset is high at an edge, every ID_EX_* output SHALL be 0, stall_count SHALL be 0, and reset SHALL override ex_flush and hazard.
REQ-029 stall SHALL be 0 in the first cycle after reset because ID_EX_valid=0; reset asserted mid-stall SHALL clear the pending stall in that cycle.

Configuration
REQ-030 With HAZARD_STATS_EN defined, stall_count SHALL increment by 1 on each edge where stall=1, saturating at 0xFFFF_FFFF with no wrap.
REQ-031 Without HAZARD_STATS_EN, stall_count SHALL be tied to 0, the port SHALL remain present, and no counter flops SHALL be inferred.

Verification
REQ-032 ID_EX holds lw x5 (ctrl=3'b110, valid); ID has add x6,x5,x7 with id_use=2'b11 -> stall=1 for one cycle, then ID_EX_valid=0, ID_EX_ctrl=0; the next edge loads the add.
REQ-033 ID_EX holds lw x0; ID reads x0 -> stall=0, no bubble.
REQ-034 ID_EX holds lw x5; ID is an I-type instruction with rs2 field=5 and id_use=2'b01 -> stall=0.
REQ-035 Hazard and ex_flush in the same cycle -> stall=0, bubble loaded, stall_count unchanged.
REQ-036 With HAZARD_STATS_EN, three separated load-use pairs -> stall_count=3; assert reset -> all outputs 0 at the next edge.
